// File: rtl/call_ret_seq_pkg.sv
// ---------------------------------------------------------------------------
// ctrlpim_seq_pkg
//   Shared types for the CtrlPIM program sequencer.
//   seq_op_t    : decoded control opcodes (5 and 6 are illegal)
//   seq_state_t : sequencer states
//   fault_t     : sticky fault codes reported on fault_code
// ---------------------------------------------------------------------------
package ctrlpim_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRZ  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd7
  } seq_op_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_FAULT    = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_OVERFLOW  = 2'd1,
    FC_UNDERFLOW = 2'd2,
    FC_ILLEGAL   = 2'd3
  } fault_t;

endpackage

// File: rtl/call_ret_seq.sv
// ---------------------------------------------------------------------------
// call_ret_seq
//   Program sequencer for the CtrlPIM controller. Accepts decoded control
//   ops, keeps the program counter and drives the external return-address
//   stack (push/pop/d), consuming its q/full/empty. Call overflow, return
//   underflow and illegal ops put the sequencer into a sticky FAULT state.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   instr_valid/ready     op handshake; ready only in RUN
//   instr_op              seq_op_t opcode
//   instr_target          jump / branch / call target
//   cond_zero             BRZ condition, sampled at accept
//   pc                    current program counter
//   stk_push/pop/d        stack strobes and return address (combinational)
//   stk_q/full/empty      stack read data (valid cycle after pop) and flags
//   depth                 local call depth (debug)
//   halted, fault         terminal-state indicators
//   fault_code            fault_t reason, held until reset
// ---------------------------------------------------------------------------
module call_ret_seq
  import ctrlpim_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RESET_PC  = 0,
  parameter int MAX_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           instr_valid,
  output logic                           instr_ready,
  input  logic [2:0]                     instr_op,
  input  logic [WIDTH-1:0]               instr_target,
  input  logic                           cond_zero,
  output logic [WIDTH-1:0]               pc,
  output logic                           stk_push,
  output logic                           stk_pop,
  output logic [WIDTH-1:0]               stk_d,
  input  logic [WIDTH-1:0]               stk_q,
  input  logic                           stk_full,
  input  logic                           stk_empty,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic                           halted,
  output logic                           fault,
  output logic [1:0]                     fault_code
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0]    MAX_D    = DW'(MAX_DEPTH);
  localparam logic [WIDTH-1:0] PC_RESET = WIDTH'(RESET_PC);

  seq_state_t       state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [DW-1:0]    depth_reg, depth_next;
  fault_t           fault_code_reg, fault_code_next;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc_reg + 1'b1;  // wraps naturally at 2^WIDTH-1

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      pc_reg         <= PC_RESET;
      depth_reg      <= '0;
      fault_code_reg <= FC_NONE;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      depth_reg      <= depth_next;
      fault_code_reg <= fault_code_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    depth_next      = depth_reg;
    fault_code_next = fault_code_reg;
    stk_push        = 1'b0;
    stk_pop         = 1'b0;
    stk_d           = '0;

    unique case (state_reg)
      ST_RUN: begin
        if (instr_valid) begin
          case (instr_op)
            OP_NOP: pc_next = pc_inc;
            OP_JMP: pc_next = instr_target;
            OP_BRZ: pc_next = cond_zero ? instr_target : pc_inc;
            OP_CALL: begin
              // The stack flag and the local counter must both allow the
              // push; any disagreement is treated as an overflow.
              if (!stk_full && (depth_reg < MAX_D)) begin
                stk_push   = 1'b1;
                stk_d      = pc_inc;
                pc_next    = instr_target;
                depth_next = depth_reg + 1'b1;
              end else begin
                state_next      = ST_FAULT;
                fault_code_next = FC_OVERFLOW;
              end
            end
            OP_RET: begin
              if (!stk_empty && (depth_reg != '0)) begin
                stk_pop    = 1'b1;
                depth_next = depth_reg - 1'b1;
                state_next = ST_RET_WAIT;
              end else begin
                state_next      = ST_FAULT;
                fault_code_next = FC_UNDERFLOW;
              end
            end
            OP_HALT: state_next = ST_HALT;
            default: begin
              state_next      = ST_FAULT;
              fault_code_next = FC_ILLEGAL;
            end
          endcase
        end
      end
      // Stack read data arrives one cycle after the pop strobe.
      ST_RET_WAIT: begin
        pc_next    = stk_q;
        state_next = ST_RUN;
      end
      default: ;  // HALT and FAULT hold everything until reset
    endcase
  end

  assign instr_ready = (state_reg == ST_RUN);
  assign pc          = pc_reg;
  assign depth       = depth_reg;
  assign halted      = (state_reg == ST_HALT);
  assign fault       = (state_reg == ST_FAULT);
  assign fault_code  = fault_code_reg;

endmodule

// File: tb/tb_call_ret_seq.sv
// ---------------------------------------------------------------------------
// tb_call_ret_seq
//   Self-checking bench for call_ret_seq. A behavioural return-address
//   stack drives stk_q/full/empty; a queue-based reference model predicts
//   pc, depth, strobes and faults for directed and randomized op streams.
// ---------------------------------------------------------------------------
module tb_call_ret_seq;

  localparam int WIDTH     = 16;
  localparam int MAX_DEPTH = 16;
  localparam int DW        = $clog2(MAX_DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [2:0]       instr_op = 3'd0;
  logic [WIDTH-1:0] instr_target = '0;
  logic             cond_zero = 1'b0;
  logic [WIDTH-1:0] pc;
  logic             stk_push, stk_pop;
  logic [WIDTH-1:0] stk_d;
  logic [WIDTH-1:0] stk_q;
  logic             stk_full, stk_empty;
  logic [DW-1:0]    depth;
  logic             halted, fault;
  logic [1:0]       fault_code;

  always #5 clk = ~clk;

  call_ret_seq #(.WIDTH(WIDTH), .RESET_PC(0), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_target(instr_target), .cond_zero(cond_zero),
    .pc(pc), .stk_push(stk_push), .stk_pop(stk_pop), .stk_d(stk_d),
    .stk_q(stk_q), .stk_full(stk_full), .stk_empty(stk_empty),
    .depth(depth), .halted(halted), .fault(fault), .fault_code(fault_code)
  );

  // Behavioural external stack sharing the reset; q registered on pop.
  logic [WIDTH-1:0] smem [MAX_DEPTH];
  int               sp;
  assign stk_full  = (sp == MAX_DEPTH);
  assign stk_empty = (sp == 0);

  always @(posedge clk) begin
    if (reset) begin
      sp    <= 0;
      stk_q <= '0;
    end else if (stk_push && sp < MAX_DEPTH) begin
      smem[sp] <= stk_d;
      sp       <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_q <= smem[sp-1];
      sp    <= sp - 1;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] m_stack [$];
  bit               m_halted, m_fault;
  int               m_code;

  // Expected / observed per op
  bit               exp_push, exp_pop, exp_bubble;
  logic [WIDTH-1:0] exp_d;
  logic             obs_push, obs_pop, obs_bubble;
  logic [WIDTH-1:0] obs_d;

  task automatic model_reset();
    m_pc = '0;
    m_stack.delete();
    m_halted = 0;
    m_fault = 0;
    m_code = 0;
  endtask

  task automatic model_op(input logic [2:0] op, input logic [WIDTH-1:0] tgt, input logic cz);
    logic [WIDTH-1:0] next_addr;
    next_addr = m_pc + 16'd1;
    exp_push = 0; exp_pop = 0; exp_bubble = 0; exp_d = '0;
    case (op)
      3'd0: m_pc = next_addr;
      3'd1: m_pc = tgt;
      3'd2: m_pc = cz ? tgt : next_addr;
      3'd3: begin
        if (m_stack.size() < MAX_DEPTH) begin
          exp_push = 1; exp_d = next_addr;
          m_stack.push_back(next_addr);
          m_pc = tgt;
        end else begin
          m_fault = 1; m_code = 1;
        end
      end
      3'd4: begin
        if (m_stack.size() > 0) begin
          exp_pop = 1; exp_bubble = 1;
          m_pc = m_stack.pop_back();
        end else begin
          m_fault = 1; m_code = 2;
        end
      end
      3'd7: m_halted = 1;
      default: begin m_fault = 1; m_code = 3; end
    endcase
  endtask

  // Waits (bounded) for ready, presents one op, records strobes, and for an
  // accepted RET also records whether the bubble cycle showed ready=0.
  task automatic step(input logic [2:0] op, input logic [WIDTH-1:0] tgt, input logic cz);
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: instr_ready=%b required 1", instr_ready);
    end
    instr_valid = 1'b1; instr_op = op; instr_target = tgt; cond_zero = cz;
    #1;
    obs_push = stk_push; obs_pop = stk_pop; obs_d = stk_d;
    model_op(op, tgt, cz);
    @(posedge clk); #1;
    instr_valid = 1'b0; instr_op = 3'd0;
    obs_bubble = 1'b0;
    if (exp_bubble) begin
      obs_bubble = !instr_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    checks++;
    if (pc !== 16'h0000 || depth !== '0) begin
      errors++; $display("FAIL reset_pc_depth: pc=%h depth=%0d required pc=0000 depth=0", pc, depth);
    end
    checks++;
    if (instr_ready !== 1'b1 || stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_d !== '0) begin
      errors++; $display("FAIL reset_strobes: ready=%b push=%b pop=%b d=%h required 1 0 0 0000",
                         instr_ready, stk_push, stk_pop, stk_d);
    end
    checks++;
    if (halted !== 1'b0 || fault !== 1'b0 || fault_code !== 2'd0) begin
      errors++; $display("FAIL reset_status: halted=%b fault=%b code=%0d required 0 0 0", halted, fault, fault_code);
    end
    $display("reset: pc=%h depth=%0d ready=%b", pc, depth, instr_ready);
  endtask

  task automatic test_nop();
    test_reset();
    for (int i = 1; i <= 3; i++) begin
      step(3'd0, '0, 1'b0);
      checks++;
      if (pc !== 16'(i) || obs_push !== 1'b0 || obs_pop !== 1'b0 || instr_ready !== 1'b1) begin
        errors++; $display("FAIL nop_%0d: pc=%h push=%b pop=%b ready=%b required pc=%h 0 0 1",
                           i, pc, obs_push, obs_pop, instr_ready, 16'(i));
      end
      $display("nop: pc=%h", pc);
    end
  endtask

  task automatic test_call_ret();
    test_reset();
    step(3'd1, 16'h0005, 1'b0);
    step(3'd3, 16'h0040, 1'b0);
    checks++;
    if (obs_push !== 1'b1 || obs_d !== 16'h0006 || pc !== 16'h0040 || depth !== 5'd1) begin
      errors++; $display("FAIL call: push=%b d=%h pc=%h depth=%0d required 1 0006 0040 1",
                         obs_push, obs_d, pc, depth);
    end
    $display("call: d=%h pc=%h depth=%0d", obs_d, pc, depth);
    step(3'd0, '0, 1'b0);
    checks++;
    if (pc !== 16'h0041 || obs_push !== 1'b0) begin
      errors++; $display("FAIL call_nop: pc=%h push=%b required 0041 0", pc, obs_push);
    end
    step(3'd4, '0, 1'b0);
    checks++;
    if (obs_pop !== 1'b1 || obs_push !== 1'b0 || obs_bubble !== 1'b1 || pc !== 16'h0006 || depth !== 5'd0) begin
      errors++; $display("FAIL ret: pop=%b push=%b bubble=%b pc=%h depth=%0d required 1 0 1 0006 0",
                         obs_pop, obs_push, obs_bubble, pc, depth);
    end
    $display("ret: pc=%h depth=%0d bubble=%b", pc, depth, obs_bubble);
  endtask

  task automatic test_nested();
    int peak;
    test_reset();
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      step((i < 3) ? 3'd3 : 3'd4, 16'($urandom), 1'b0);
      if (int'(depth) > peak) peak = int'(depth);
      checks++;
      if (obs_push !== exp_push || obs_pop !== exp_pop || obs_d !== exp_d ||
          pc !== m_pc || depth !== DW'(m_stack.size())) begin
        errors++; $display("FAIL nested_%0d: push=%b pop=%b d=%h pc=%h depth=%0d required %b %b %h %h %0d",
                           i, obs_push, obs_pop, obs_d, pc, depth, exp_push, exp_pop, exp_d, m_pc, m_stack.size());
      end
      $display("nested: op=%0d pc=%h depth=%0d", (i < 3) ? 3 : 4, pc, depth);
    end
    checks++;
    if (peak != 3) begin
      errors++; $display("FAIL nested_peak: peak=%0d required 3", peak);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    test_reset();
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 4));
      if (op == 3'd3 && m_stack.size() == MAX_DEPTH) op = 3'd0;
      if (op == 3'd4 && m_stack.size() == 0) op = 3'd2;
      step(op, 16'($urandom), 1'($urandom));
      checks++;
      if (obs_push !== exp_push || obs_pop !== exp_pop || obs_d !== exp_d || obs_bubble !== exp_bubble ||
          pc !== m_pc || depth !== DW'(m_stack.size()) || fault !== 1'b0 || (obs_push & obs_pop) !== 1'b0) begin
        errors++; $display("FAIL random_%0d op=%0d: push=%b pop=%b d=%h bub=%b pc=%h depth=%0d fault=%b required %b %b %h %b %h %0d 0",
                           i, op, obs_push, obs_pop, obs_d, obs_bubble, pc, depth, fault,
                           exp_push, exp_pop, exp_d, exp_bubble, m_pc, m_stack.size());
      end
      $display("random: op=%0d pc=%h depth=%0d", op, pc, depth);
    end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] hold_pc;
    test_reset();
    for (int i = 0; i < MAX_DEPTH; i++) begin
      step(3'd3, 16'($urandom), 1'b0);
      checks++;
      if (obs_push !== 1'b1 || obs_d !== exp_d || pc !== m_pc) begin
        errors++; $display("FAIL ovf_call_%0d: push=%b d=%h pc=%h required 1 %h %h", i, obs_push, obs_d, pc, exp_d, m_pc);
      end
    end
    hold_pc = pc;
    step(3'd3, 16'h1234, 1'b0);
    checks++;
    if (obs_push !== 1'b0 || fault !== 1'b1 || fault_code !== 2'd1 || pc !== hold_pc ||
        depth !== DW'(MAX_DEPTH) || instr_ready !== 1'b0) begin
      errors++; $display("FAIL overflow: push=%b fault=%b code=%0d pc=%h depth=%0d ready=%b required 0 1 1 %h %0d 0",
                         obs_push, fault, fault_code, pc, depth, instr_ready, hold_pc, MAX_DEPTH);
    end
    $display("overflow: fault=%b code=%0d pc=%h", fault, fault_code, pc);
    instr_valid = 1'b1; instr_op = 3'd3; instr_target = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stk_push !== 1'b0 || stk_pop !== 1'b0 || pc !== hold_pc || fault_code !== 2'd1) begin
        errors++; $display("FAIL ovf_ignore_%0d: push=%b pop=%b pc=%h code=%0d required 0 0 %h 1",
                           i, stk_push, stk_pop, pc, fault_code, hold_pc);
      end
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_underflow();
    test_reset();
    step(3'd4, '0, 1'b0);
    checks++;
    if (obs_pop !== 1'b0 || fault !== 1'b1 || fault_code !== 2'd2 || pc !== 16'h0000) begin
      errors++; $display("FAIL underflow: pop=%b fault=%b code=%0d pc=%h required 0 1 2 0000",
                         obs_pop, fault, fault_code, pc);
    end
    $display("underflow: fault=%b code=%0d", fault, fault_code);
    test_reset();
  endtask

  task automatic test_illegal();
    test_reset();
    step(3'd1, 16'h0077, 1'b0);
    step(3'd5, 16'h0999, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd3 || pc !== 16'h0077) begin
      errors++; $display("FAIL illegal: fault=%b code=%0d pc=%h required 1 3 0077", fault, fault_code, pc);
    end
    $display("illegal: code=%0d pc=%h", fault_code, pc);
  endtask

  task automatic test_wrap_brz_halt();
    test_reset();
    step(3'd1, 16'hFFFF, 1'b0);
    step(3'd0, '0, 1'b0);
    checks++;
    if (pc !== 16'h0000) begin
      errors++; $display("FAIL wrap: pc=%h required 0000", pc);
    end
    step(3'd2, 16'h1234, 1'b0);
    checks++;
    if (pc !== 16'h0001) begin
      errors++; $display("FAIL brz_not_taken: pc=%h required 0001", pc);
    end
    step(3'd2, 16'h1234, 1'b1);
    checks++;
    if (pc !== 16'h1234) begin
      errors++; $display("FAIL brz_taken: pc=%h required 1234", pc);
    end
    step(3'd7, 16'h5555, 1'b0);
    checks++;
    if (halted !== 1'b1 || instr_ready !== 1'b0 || pc !== 16'h1234 || fault !== 1'b0) begin
      errors++; $display("FAIL halt: halted=%b ready=%b pc=%h fault=%b required 1 0 1234 0",
                         halted, instr_ready, pc, fault);
    end
    $display("halt: halted=%b pc=%h", halted, pc);
  endtask

  task automatic test_reset_mid_ret();
    test_reset();
    step(3'd3, 16'h0020, 1'b0);
    instr_valid = 1'b1; instr_op = 3'd4;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr_op = 3'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (pc !== 16'h0000 || depth !== '0 || instr_ready !== 1'b1 || fault !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ret: pc=%h depth=%0d ready=%b fault=%b required 0000 0 1 0",
                         pc, depth, instr_ready, fault);
    end
    $display("reset_mid_ret: pc=%h depth=%0d", pc, depth);
  endtask

  initial begin
    test_reset();
    test_nop();
    test_call_ret();
    test_nested();
    test_overflow();
    test_underflow();
    test_illegal();
    test_wrap_brz_halt();
    test_reset_mid_ret();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
